// File: rtl/c0_req_arb.sv
// c0_req_arb -- round-robin C0 read-request arbiter with response fan-out.
//
// Optional feature macro: C0_REQ_ARB_STATS_EN. When it is defined, req_cnt
// and rsp_cnt are free-running 32-bit counters. When it is not defined, both
// ports are tied to zero and no counter flops exist.
//
// Ports
//   pClk, pck_cp2af_softReset_n   clock; async active-low reset
//   req_valid/addr/mdata          per-port read requests (NUM_PORTS lanes)
//   req_ready                     one-hot combinational grant
//   up_almfull                    upstream almost-full; blocks every grant
//   up_valid/addr/mdata           registered upstream request; mdata = {port, mdata[11:0]}
//   rsp_in_valid/mdata/data       upstream read response
//   rsp_valid/mdata/data          registered response; routed by rsp_in_mdata[15:12]
//   bad_port_err                  sticky flag for a response whose port id is out of range
//   req_cnt, rsp_cnt              grant and routed-response counters

// Per-port response decode: this lane is hit when the response carries its id.
module c0_req_arb_lane #(
  parameter int LANE = 0
) (
  input  logic       hit,
  input  logic [3:0] portId,
  output logic       sel
);
  assign sel = hit && (portId == 4'(LANE));
endmodule

module c0_req_arb #(
  parameter int NUM_PORTS = 9
) (
  input  logic                       pClk,
  input  logic                       pck_cp2af_softReset_n,
  input  logic [NUM_PORTS-1:0]       req_valid,
  input  logic [NUM_PORTS-1:0][41:0] req_addr,
  input  logic [NUM_PORTS-1:0][15:0] req_mdata,
  output logic [NUM_PORTS-1:0]       req_ready,
  input  logic                       up_almfull,
  output logic                       up_valid,
  output logic [41:0]                up_addr,
  output logic [15:0]                up_mdata,
  input  logic                       rsp_in_valid,
  input  logic [15:0]                rsp_in_mdata,
  input  logic [511:0]               rsp_in_data,
  output logic [NUM_PORTS-1:0]       rsp_valid,
  output logic [15:0]                rsp_mdata,
  output logic [511:0]               rsp_data,
  output logic                       bad_port_err,
  output logic [31:0]                req_cnt,
  output logic [31:0]                rsp_cnt
);

  typedef struct packed {
    logic [41:0] addr;
    logic [15:0] mdata;
  } c0ReqT;

  logic [3:0]           ptr;
  logic [3:0]           gntIdx;
  logic                 gntAny;
  logic [NUM_PORTS-1:0] gntVec;
  logic [4:0]           cand;
  c0ReqT                upReq;
  logic [NUM_PORTS-1:0] rspHit;
  logic                 badId;

  // Search from the pointer, wrapping. A 5-bit candidate holds ptr+off
  // before it is folded back into range.
  always_comb begin
    gntAny = 1'b0;
    gntIdx = '0;
    gntVec = '0;
    cand   = '0;
    if (!up_almfull && pck_cp2af_softReset_n) begin
      for (int off = 0; off < NUM_PORTS; off++) begin
        cand = {1'b0, ptr} + 5'(off);
        if (cand >= 5'(NUM_PORTS)) cand = cand - 5'(NUM_PORTS);
        if (!gntAny && req_valid[cand[3:0]]) begin
          gntAny = 1'b1;
          gntIdx = cand[3:0];
        end
      end
    end
    if (gntAny) gntVec[gntIdx] = 1'b1;
  end

  assign req_ready = gntVec;

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      ptr      <= '0;
      up_valid <= 1'b0;
      upReq    <= '0;
    end else begin
      up_valid <= gntAny;
      if (gntAny) begin
        ptr   <= (gntIdx == 4'(NUM_PORTS-1)) ? 4'd0 : gntIdx + 4'd1;
        upReq <= '{addr: req_addr[gntIdx], mdata: {gntIdx, req_mdata[gntIdx][11:0]}};
      end
    end
  end

  assign up_addr  = upReq.addr;
  assign up_mdata = upReq.mdata;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : gLane
    c0_req_arb_lane #(.LANE(i)) uLane (
      .hit    (rsp_in_valid),
      .portId (rsp_in_mdata[15:12]),
      .sel    (rspHit[i])
    );
  end

  assign badId = rsp_in_valid && ({1'b0, rsp_in_mdata[15:12]} >= 5'(NUM_PORTS));

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      rsp_valid    <= '0;
      rsp_mdata    <= '0;
      rsp_data     <= '0;
      bad_port_err <= 1'b0;
    end else begin
      rsp_valid <= rspHit;
      if (rsp_in_valid) begin
        rsp_mdata <= {4'h0, rsp_in_mdata[11:0]};
        rsp_data  <= rsp_in_data;
      end
      if (badId) bad_port_err <= 1'b1;
    end
  end

`ifdef C0_REQ_ARB_STATS_EN
  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      req_cnt <= '0;
      rsp_cnt <= '0;
    end else begin
      if (gntAny)   req_cnt <= req_cnt + 32'd1;
      if (|rspHit)  rsp_cnt <= rsp_cnt + 32'd1;
    end
  end
`else
  assign req_cnt = '0;
  assign rsp_cnt = '0;
`endif

endmodule

// File: tb/tb_c0_req_arb.sv
// Randomized and directed bench for c0_req_arb against a queue-free
// behavioural model: pointer + expected registered outputs.
module tb_c0_req_arb;
  localparam int NP = 9;

  logic                pClk = 1'b0;
  logic                rstN;
  logic [NP-1:0]       reqValid;
  logic [NP-1:0][41:0] reqAddr;
  logic [NP-1:0][15:0] reqMdata;
  logic [NP-1:0]       reqReady;
  logic                upAlmfull;
  logic                upValid;
  logic [41:0]         upAddr;
  logic [15:0]         upMdata;
  logic                rspInValid;
  logic [15:0]         rspInMdata;
  logic [511:0]        rspInData;
  logic [NP-1:0]       rspValid;
  logic [15:0]         rspMdata;
  logic [511:0]        rspData;
  logic                badPortErr;
  logic [31:0]         reqCnt, rspCnt;

  int total = 0;
  int bad   = 0;

  // model state
  int            mPtr;
  logic          mUpValid;
  logic [41:0]   mUpAddr;
  logic [15:0]   mUpMdata;
  logic [NP-1:0] mRspValid;
  logic [15:0]   mRspMdata;
  logic [511:0]  mRspData;
  logic          mBad;
  int            mReqCnt, mRspCnt;

  c0_req_arb #(.NUM_PORTS(NP)) dut (
    .pClk(pClk), .pck_cp2af_softReset_n(rstN),
    .req_valid(reqValid), .req_addr(reqAddr), .req_mdata(reqMdata), .req_ready(reqReady),
    .up_almfull(upAlmfull), .up_valid(upValid), .up_addr(upAddr), .up_mdata(upMdata),
    .rsp_in_valid(rspInValid), .rsp_in_mdata(rspInMdata), .rsp_in_data(rspInData),
    .rsp_valid(rspValid), .rsp_mdata(rspMdata), .rsp_data(rspData),
    .bad_port_err(badPortErr), .req_cnt(reqCnt), .rsp_cnt(rspCnt)
  );

  always #5 pClk = ~pClk;

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // First requesting port at or after the pointer, wrapping.
  function automatic logic [NP-1:0] exp_ready(int ptr, logic [NP-1:0] v, logic af);
    logic [NP-1:0] r;
    r = '0;
    if (af) return r;
    for (int o = 0; o < NP; o++) begin
      if (v[(ptr + o) % NP]) begin
        r[(ptr + o) % NP] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic int exp_cnt(int c);
`ifdef C0_REQ_ARB_STATS_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    mPtr = 0; mUpValid = 0; mUpAddr = '0; mUpMdata = '0;
    mRspValid = '0; mRspMdata = '0; mRspData = '0; mBad = 0;
    mReqCnt = 0; mRspCnt = 0;
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic [NP-1:0] g;
    int p;
    g = exp_ready(mPtr, reqValid, upAlmfull);
    mUpValid = (g != '0);
    for (int k = 0; k < NP; k++) begin
      if (g[k]) begin
        mUpAddr  = reqAddr[k];
        mUpMdata = {4'(k), reqMdata[k][11:0]};
        mPtr     = (k + 1) % NP;
        mReqCnt++;
      end
    end
    mRspValid = '0;
    if (rspInValid) begin
      mRspData  = rspInData;
      mRspMdata = {4'h0, rspInMdata[11:0]};
      p = int'(rspInMdata[15:12]);
      if (p < NP) begin
        mRspValid[p] = 1'b1;
        mRspCnt++;
      end else mBad = 1'b1;
    end
  endtask

  task automatic drive_idle();
    reqValid = '0; upAlmfull = 0; rspInValid = 0; rspInMdata = '0;
    for (int i = 0; i < NP; i++) begin
      reqAddr[i]  = {$urandom, $urandom} & 42'h3FF_FFFF_FFFF;
      reqMdata[i] = 16'($urandom);
    end
    rspInData = rand512();
  endtask

  task automatic do_reset();
    @(negedge pClk);
    drive_idle();
    rstN = 0;
    model_reset();
    #2;
    @(negedge pClk);
    rstN = 1;
  endtask

  task automatic test_reset();
    drive_idle();
    reqValid = '1;
    rstN = 0;
    model_reset();
    #3;
    total++; if (reqReady !== '0) begin bad++; $display("FAIL reset_ready got %h want 0", reqReady); end
    total++; if ({upValid, upAddr, upMdata} !== '0) begin bad++; $display("FAIL reset_up got %b %h %h want 0", upValid, upAddr, upMdata); end
    total++; if ({rspValid, rspMdata, badPortErr} !== '0 || rspData !== '0) begin bad++; $display("FAIL reset_rsp got %h %h %b want 0", rspValid, rspMdata, badPortErr); end
    total++; if (reqCnt !== 0 || rspCnt !== 0) begin bad++; $display("FAIL reset_cnt got %0d %0d want 0", reqCnt, rspCnt); end
    @(negedge pClk);
    rstN = 1;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      reqValid = '1;
      #1;
      total++; if (reqReady !== NP'(1) << (i % NP)) begin bad++; $display("FAIL rr_ready[%0d] got %h want %h", i, reqReady, NP'(1) << (i % NP)); end
      model_edge();
      @(posedge pClk); @(negedge pClk);
      total++; if (upValid !== 1'b1 || upMdata[15:12] !== 4'(i % NP) || upAddr !== reqAddr[i % NP]) begin
        bad++; $display("FAIL rr_up[%0d] got %b %h %h want port %0d", i, upValid, upMdata, upAddr, i % NP);
      end
    end
  endtask

  task automatic test_port3();
    do_reset();
    reqValid = NP'(1) << 3;
    reqMdata[3] = 16'hFABC;
    #1;
    total++; if (reqReady !== NP'(9'h008)) begin bad++; $display("FAIL p3_ready got %h want 008", reqReady); end
    model_edge();
    @(posedge pClk); @(negedge pClk);
    total++; if (upValid !== 1'b1 || upMdata !== 16'h3ABC) begin bad++; $display("FAIL p3_up got %b %h want 1 3abc", upValid, upMdata); end
    reqValid = '0;
    model_edge();
    @(posedge pClk); @(negedge pClk);
    total++; if (upValid !== 1'b0 || upMdata !== 16'h3ABC) begin bad++; $display("FAIL p3_hold got %b %h want 0 3abc", upValid, upMdata); end
  endtask

  task automatic test_almfull();
    do_reset();
    reqValid = NP'(9'h024);
    for (int i = 0; i < 6; i++) begin
      upAlmfull = (i < 4);
      #1;
      total++; if (reqReady !== (i < 4 ? NP'(0) : (i == 4 ? NP'(9'h004) : NP'(9'h020)))) begin
        bad++; $display("FAIL af_ready[%0d] got %h", i, reqReady);
      end
      model_edge();
      @(posedge pClk); @(negedge pClk);
      total++; if (upValid !== (i >= 4)) begin bad++; $display("FAIL af_up[%0d] got %b want %b", i, upValid, i >= 4); end
    end
  endtask

  task automatic test_response();
    do_reset();
    rspInValid = 1; rspInMdata = 16'h7123; rspInData = rand512();
    model_edge();
    @(posedge pClk); @(negedge pClk);
    total++; if (rspValid !== NP'(9'h080) || rspMdata !== 16'h0123 || rspData !== mRspData) begin
      bad++; $display("FAIL rsp_route got %h %h want 080 0123", rspValid, rspMdata);
    end
    rspInMdata = 16'hC000;
    model_edge();
    @(posedge pClk); @(negedge pClk);
    total++; if (rspValid !== '0 || badPortErr !== 1'b1) begin bad++; $display("FAIL rsp_badport got %h %b want 0 1", rspValid, badPortErr); end
    rspInValid = 0;
    repeat (2) begin model_edge(); @(posedge pClk); @(negedge pClk); end
    total++; if (badPortErr !== 1'b1 || rspValid !== '0) begin bad++; $display("FAIL rsp_sticky got %b %h want 1 0", badPortErr, rspValid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) begin
        reqAddr[i]  = {$urandom, $urandom} & 42'h3FF_FFFF_FFFF;
        reqMdata[i] = 16'($urandom);
      end
      reqValid   = NP'($urandom) & NP'($urandom);
      upAlmfull  = ($urandom_range(0, 3) == 0);
      rspInValid = $urandom_range(0, 1) == 1;
      rspInMdata = {4'($urandom_range(0, (c < 300) ? NP - 1 : 15)), 12'($urandom)};
      rspInData  = rand512();
      #1;
      total++; if (reqReady !== exp_ready(mPtr, reqValid, upAlmfull)) begin
        bad++; $display("FAIL rnd_ready[%0d] got %h want %h", c, reqReady, exp_ready(mPtr, reqValid, upAlmfull));
      end
      model_edge();
      @(posedge pClk); @(negedge pClk);
      total++; if (upValid !== mUpValid || upAddr !== mUpAddr || upMdata !== mUpMdata) begin
        bad++; $display("FAIL rnd_up[%0d] got %b %h %h want %b %h %h", c, upValid, upAddr, upMdata, mUpValid, mUpAddr, mUpMdata);
      end
      total++; if (rspValid !== mRspValid || rspMdata !== mRspMdata || rspData !== mRspData || badPortErr !== mBad) begin
        bad++; $display("FAIL rnd_rsp[%0d] got %h %h %b want %h %h %b", c, rspValid, rspMdata, badPortErr, mRspValid, mRspMdata, mBad);
      end
      total++; if (reqCnt !== 32'(exp_cnt(mReqCnt)) || rspCnt !== 32'(exp_cnt(mRspCnt))) begin
        bad++; $display("FAIL rnd_cnt[%0d] got %0d %0d want %0d %0d", c, reqCnt, rspCnt, exp_cnt(mReqCnt), exp_cnt(mRspCnt));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    reqValid = '1; rspInValid = 1; rspInMdata = 16'h2555; rspInData = rand512();
    model_edge();
    @(posedge pClk); @(negedge pClk);
    total++; if (upValid !== 1'b1 || rspValid !== NP'(9'h004)) begin bad++; $display("FAIL mid_pre got %b %h want 1 004", upValid, rspValid); end
    #2;
    rstN = 0;
    model_reset();
    #1;
    total++; if ({upValid, upAddr, upMdata, rspValid, rspMdata, badPortErr, reqReady} !== '0 || rspData !== '0) begin
      bad++; $display("FAIL mid_reset got %b %h %h %h %h ready %h", upValid, upAddr, upMdata, rspValid, rspMdata, reqReady);
    end
    total++; if (reqCnt !== 0 || rspCnt !== 0) begin bad++; $display("FAIL mid_cnt got %0d %0d want 0", reqCnt, rspCnt); end
    @(negedge pClk);
    rstN = 1; rspInValid = 0;
    #1;
    total++; if (reqReady !== NP'(1)) begin bad++; $display("FAIL mid_prio got %h want 001", reqReady); end
    model_edge();
    @(posedge pClk); @(negedge pClk);
    total++; if (upValid !== 1'b1 || upMdata[15:12] !== 4'h0 || rspValid !== '0) begin
      bad++; $display("FAIL mid_first got %b %h %h want port 0", upValid, upMdata, rspValid);
    end
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      reqValid = '1; rspInValid = 1;
      rspInMdata = {4'(i % NP), 12'($urandom)};
      model_edge();
      @(posedge pClk); @(negedge pClk);
    end
    drive_idle();
    model_edge();
    @(posedge pClk); @(negedge pClk);
    total++; if (reqCnt !== 32'(exp_cnt(100))) begin bad++; $display("FAIL stats_req got %0d want %0d", reqCnt, exp_cnt(100)); end
    total++; if (rspCnt !== 32'(exp_cnt(100))) begin bad++; $display("FAIL stats_rsp got %0d want %0d", rspCnt, exp_cnt(100)); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_port3();
    test_almfull();
    test_response();
    test_random();
    test_reset_mid();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
